// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw async level; q_o follows after SYNC_STAGES+DB_CYCLES edges.
// Optional rise/fall pulses are built only when DEBOUNCE_SYNC_EDGE_EN is defined.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 10,
  parameter int DB_CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

  localparam logic [DB_CNT_W:0] DB_LIM = (DB_CNT_W + 1)'(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [DB_CNT_W-1:0]    cnt;
  logic [DB_CNT_W:0]      cnt_inc;
  logic                   cnt_done;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], d_i};
  end

  assign s        = sync[SYNC_STAGES-1];
  // One extra bit so the compare never sees a wrapped count.
  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  assign cnt_done = (cnt_inc == DB_LIM);

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_q, fall_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE_LO;
      cnt   <= '0;
      q_o   <= 1'b0;
`ifdef DEBOUNCE_SYNC_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_SYNC_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      case (state)
        STABLE_LO: begin
          if (s) begin
            if (DB_CYCLES == 1) begin
              q_o   <= 1'b1;
              state <= STABLE_HI;
`ifdef DEBOUNCE_SYNC_EDGE_EN
              rise_q <= 1'b1;
`endif
            end else begin
              cnt   <= DB_CNT_W'(1);
              state <= PEND_HI;
            end
          end
        end
        PEND_HI: begin
          if (!s) begin
            cnt   <= '0;
            state <= STABLE_LO;
          end else if (cnt_done) begin
            q_o   <= 1'b1;
            cnt   <= '0;
            state <= STABLE_HI;
`ifdef DEBOUNCE_SYNC_EDGE_EN
            rise_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc[DB_CNT_W-1:0];
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (DB_CYCLES == 1) begin
              q_o   <= 1'b0;
              state <= STABLE_LO;
`ifdef DEBOUNCE_SYNC_EDGE_EN
              fall_q <= 1'b1;
`endif
            end else begin
              cnt   <= DB_CNT_W'(1);
              state <= PEND_LO;
            end
          end
        end
        PEND_LO: begin
          if (s) begin
            cnt   <= '0;
            state <= STABLE_HI;
          end else if (cnt_done) begin
            q_o   <= 1'b0;
            cnt   <= '0;
            state <= STABLE_LO;
`ifdef DEBOUNCE_SYNC_EDGE_EN
            fall_q <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc[DB_CNT_W-1:0];
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE_LO;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_SYNC_EDGE_EN
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

  assign busy_o = (state == PEND_HI) || (state == PEND_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: latency tables, corner sequences, and random run-length stimulus.
module tb_debounce_sync;

  localparam int S  = 2;
  localparam int DB = 10;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_i = 1'b0;
  logic q_o, rise_o, fall_o, busy_o;

  int checks = 0;
  int failures = 0;

  debounce_sync #(.SYNC_STAGES(S), .DB_CYCLES(DB), .DB_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_i(d_i),
    .q_o(q_o), .rise_o(rise_o), .fall_o(fall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference: q follows s once s has disagreed with q on DB consecutive edges.
  logic m_sync [S];
  logic m_q, m_rise, m_fall;
  int   m_run;
  logic dq, dr, df, db;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic d);
    logic s_old;
    if (r) begin
      for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
      m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      s_old  = m_sync[S-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s_old != m_q) begin
        m_run++;
        if (m_run == DB) begin
          m_q    = s_old;
          m_rise = EDGE && s_old;
          m_fall = EDGE && !s_old;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = d;
    end
  endtask

  task automatic step(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    d_i   = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    dq = q_o; dr = rise_o; df = fall_o; db = busy_o;
    chk("model_q", dq, m_q);
    chk("model_rise", dr, m_rise);
    chk("model_fall", df, m_fall);
    chk("model_busy", db, (m_run != 0));
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vec_t v;
    int n_rise, n_fall, rise_edge, busy_cnt, q_min, len;
    logic lvl;

    // Reset held 3 cycles with d_i=1, then rise through the full latency.
    for (int k = 0; k < 3; k++) begin
      v = '{rst: 1'b1, d: 1'b1, q: 1'b0, rise: 1'b0, fall: 1'b0, busy: 1'b0};
      vecs.push_back(v);
    end
    for (int k = 1; k <= 14; k++) begin
      v = '{rst: 1'b0, d: 1'b1, q: (k >= 12), rise: EDGE && (k == 12),
            fall: 1'b0, busy: (k >= 3 && k <= 11)};
      vecs.push_back(v);
    end
    // Clean 1->0 step from the settled high level.
    for (int k = 1; k <= 14; k++) begin
      v = '{rst: 1'b0, d: 1'b0, q: (k < 12), rise: 1'b0,
            fall: EDGE && (k == 12), busy: (k >= 3 && k <= 11)};
      vecs.push_back(v);
    end
    // Clean 0->1 step again.
    for (int k = 1; k <= 14; k++) begin
      v = '{rst: 1'b0, d: 1'b1, q: (k >= 12), rise: EDGE && (k == 12),
            fall: 1'b0, busy: (k >= 3 && k <= 11)};
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].d);
      chk($sformatf("tbl_q[%0d]", i), dq, vecs[i].q);
      chk($sformatf("tbl_rise[%0d]", i), dr, vecs[i].rise);
      chk($sformatf("tbl_fall[%0d]", i), df, vecs[i].fall);
      chk($sformatf("tbl_busy[%0d]", i), db, vecs[i].busy);
    end

    // Bounce 1,0,1,0 (3 cycles each) from a settled low, then hold 1.
    step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    n_rise = 0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 3; k++) begin
        step(1'b0, (b % 2 == 0));
        n_rise += dr;
      end
    chk("bounce_no_rise", n_rise, 0);
    chk("bounce_q_low", dq, 0);
    rise_edge = -1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1);
      if (dr) begin
        n_rise++;
        if (rise_edge < 0) rise_edge = k;
      end
    end
    chk("bounce_rise_cnt", n_rise, EDGE ? 1 : 0);
    chk("bounce_rise_edge", rise_edge, EDGE ? 12 : -1);
    chk("bounce_q_high", dq, 1);

    // 5-cycle low glitch while q_o is high.
    n_fall = 0; busy_cnt = 0; q_min = 1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      n_fall += df; busy_cnt += db; if (!dq) q_min = 0;
    end
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1);
      n_fall += df; busy_cnt += db; if (!dq) q_min = 0;
    end
    chk("glitch_no_fall", n_fall, 0);
    chk("glitch_q_held", q_min, 1);
    chk("glitch_busy_len", busy_cnt, 5);

    // Reset while counting toward a fall (count at 6).
    n_fall = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0);
      n_fall += df;
    end
    chk("pend_lo_busy", db, 1);
    chk("pend_lo_q", dq, 1);
    step(1'b1, 1'b0);
    n_fall += df;
    chk("rst_abort_q", dq, 0);
    chk("rst_abort_busy", db, 0);
    step(1'b0, 1'b0);
    n_fall += df;
    chk("rst_abort_no_fall", n_fall, 0);
    chk("rst_abort_idle_busy", db, 0);

    // Random run-length stimulus with occasional resets.
    lvl = 1'b0;
    for (int t = 0; t < 300; t++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 199) == 0), lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
